// File: rtl/megaram_mem_bridge.sv
// MegaRAM/SCC mapper memory bridge: turns each flagged cartridge bus cycle into one SDRAM request.
// Optional request timeout is compiled in when MEM_BRIDGE_TIMEOUT_EN is defined.
module megaram_mem_bridge #(
  parameter int ADDR_W         = 23,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cart_ena,
  input  logic              ram_ena,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [7:0]        cdin,
  output logic [7:0]        cdout,
  output logic              cdout_valid,
  output logic              wait_n,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t            state, state_nx;
  logic              served, served_nx;
  logic [7:0]        cdout_nx;
  logic              cdout_valid_nx;
  logic              wait_n_nx;
  logic              mem_req_nx;
  logic              mem_wr_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [7:0]        mem_wdata_nx;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] tmo_cnt, tmo_cnt_nx;
  logic       timeout_err_nx;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      served      <= 1'b0;
      cdout       <= 8'hFF;
      cdout_valid <= 1'b0;
      wait_n      <= 1'b1;
      mem_req     <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata   <= 8'h00;
`ifdef MEM_BRIDGE_TIMEOUT_EN
      tmo_cnt     <= 8'h00;
      timeout_err <= 1'b0;
`endif
    end else begin
      state       <= state_nx;
      served      <= served_nx;
      cdout       <= cdout_nx;
      cdout_valid <= cdout_valid_nx;
      wait_n      <= wait_n_nx;
      mem_req     <= mem_req_nx;
      mem_wr      <= mem_wr_nx;
      mem_addr_o  <= mem_addr_nx;
      mem_wdata   <= mem_wdata_nx;
`ifdef MEM_BRIDGE_TIMEOUT_EN
      tmo_cnt     <= tmo_cnt_nx;
      timeout_err <= timeout_err_nx;
`endif
    end
  end

`ifndef MEM_BRIDGE_TIMEOUT_EN
  assign timeout_err = 1'b0;
`endif

  // served blocks a second request until cart_ena drops, whatever the strobes or mode do meanwhile
  always_comb begin
    state_nx       = state;
    served_nx      = cart_ena ? served : 1'b0;
    cdout_nx       = cdout;
    cdout_valid_nx = cdout_valid;
    wait_n_nx      = wait_n;
    mem_req_nx     = mem_req;
    mem_wr_nx      = mem_wr;
    mem_addr_nx    = mem_addr_o;
    mem_wdata_nx   = mem_wdata;
`ifdef MEM_BRIDGE_TIMEOUT_EN
    tmo_cnt_nx     = tmo_cnt;
    timeout_err_nx = timeout_err;
`endif

    case (state)
      IDLE: begin
        if (cart_ena && !served) begin
          if (!rd_n || (!wr_n && ram_ena)) begin
            served_nx    = 1'b1;
            mem_addr_nx  = mem_addr;
            mem_wdata_nx = cdin;
            mem_wr_nx    = rd_n;
            mem_req_nx   = 1'b1;
            wait_n_nx    = 1'b0;
            state_nx     = REQ;
`ifdef MEM_BRIDGE_TIMEOUT_EN
            tmo_cnt_nx   = 8'h00;
`endif
          end else if (!wr_n) begin
            served_nx = 1'b1;
          end
        end
      end

      REQ: begin
        // a request is never retracted; if the bus cycle already ended the read data is dropped
        if (mem_ack) begin
          mem_req_nx = 1'b0;
          wait_n_nx  = 1'b1;
          if (!mem_wr && cart_ena) begin
            cdout_nx       = mem_rdata;
            cdout_valid_nx = 1'b1;
            state_nx       = HOLD;
          end else begin
            state_nx = IDLE;
          end
        end
`ifdef MEM_BRIDGE_TIMEOUT_EN
        else if (tmo_cnt + 8'd1 == TMO_LIMIT) begin
          mem_req_nx     = 1'b0;
          wait_n_nx      = 1'b1;
          timeout_err_nx = 1'b1;
          if (!mem_wr && cart_ena) begin
            cdout_nx       = 8'hFF;
            cdout_valid_nx = 1'b1;
            state_nx       = HOLD;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          tmo_cnt_nx = tmo_cnt + 8'd1;
        end
`endif
      end

      HOLD: begin
        if (!cart_ena) begin
          cdout_nx       = 8'hFF;
          cdout_valid_nx = 1'b0;
          state_nx       = IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_megaram_mem_bridge.sv
// Table-driven bench for megaram_mem_bridge plus hand sequences for reset and timeout corners.
module tb_megaram_mem_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cart_ena, ram_ena, rd_n, wr_n, mem_ack;
  logic [22:0] mem_addr;
  logic [7:0]  cdin, mem_rdata;
  logic [7:0]  cdout, mem_wdata;
  logic        cdout_valid, wait_n, mem_req, mem_wr, timeout_err;
  logic [22:0] mem_addr_o;

  int checks = 0;
  int errors = 0;
  int req_rises = 0;
  logic req_q = 1'b0;

  always #5 clk = ~clk;

  megaram_mem_bridge #(.ADDR_W(23), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .cart_ena(cart_ena), .ram_ena(ram_ena),
    .mem_addr(mem_addr), .rd_n(rd_n), .wr_n(wr_n), .cdin(cdin),
    .cdout(cdout), .cdout_valid(cdout_valid), .wait_n(wait_n),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr_o(mem_addr_o),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .timeout_err(timeout_err)
  );

  always @(posedge clk) begin
    if (mem_req && !req_q) req_rises++;
    req_q <= mem_req;
  end

  typedef struct {
    string       name;
    logic        cart, ram, rdn, wrn;
    logic [7:0]  din;
    logic [22:0] addr;
    logic        ack;
    logic [7:0]  rdata;
    logic        e_req, e_wait_n, e_wr;
    logic [22:0] e_addr;
    logic [7:0]  e_wdata, e_cdout;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic cart, logic ram, logic rdn, logic wrn,
                              logic [7:0] din, logic [22:0] addr, logic ack, logic [7:0] rdata,
                              logic e_req, logic e_wait_n, logic e_wr, logic [22:0] e_addr,
                              logic [7:0] e_wdata, logic [7:0] e_cdout, logic e_valid);
    vec_t v;
    v.name = name; v.cart = cart; v.ram = ram; v.rdn = rdn; v.wrn = wrn;
    v.din = din; v.addr = addr; v.ack = ack; v.rdata = rdata;
    v.e_req = e_req; v.e_wait_n = e_wait_n; v.e_wr = e_wr; v.e_addr = e_addr;
    v.e_wdata = e_wdata; v.e_cdout = e_cdout; v.e_valid = e_valid;
    return v;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic cart, logic ram, logic rdn, logic wrn, logic [7:0] din,
                       logic [22:0] addr, logic ack, logic [7:0] rdata);
    cart_ena = cart; ram_ena = ram; rd_n = rdn; wr_n = wrn;
    cdin = din; mem_addr = addr; mem_ack = ack; mem_rdata = rdata;
  endtask

  task automatic applyStimulus(vec_t v);
    @(negedge clk);
    drive(v.cart, v.ram, v.rdn, v.wrn, v.din, v.addr, v.ack, v.rdata);
    @(posedge clk);
    #1;
    checkOutput({v.name, "/mem_req"},     32'(mem_req),     32'(v.e_req));
    checkOutput({v.name, "/wait_n"},      32'(wait_n),      32'(v.e_wait_n));
    checkOutput({v.name, "/mem_wr"},      32'(mem_wr),      32'(v.e_wr));
    checkOutput({v.name, "/mem_addr_o"},  32'(mem_addr_o),  32'(v.e_addr));
    checkOutput({v.name, "/mem_wdata"},   32'(mem_wdata),   32'(v.e_wdata));
    checkOutput({v.name, "/cdout"},       32'(cdout),       32'(v.e_cdout));
    checkOutput({v.name, "/cdout_valid"}, 32'(cdout_valid), 32'(v.e_valid));
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 23'h0, 1'b0, 8'h00);

    // name cart ram rd_n wr_n cdin addr ack rdata | req wait_n wr addr_o wdata cdout valid
    vecs.push_back(mk("rd0", 1,0,0,1, 8'h00, 23'h100123, 0, 8'h00, 1,0,0, 23'h100123, 8'h00, 8'hFF, 0));
    vecs.push_back(mk("rd1", 1,0,0,1, 8'h00, 23'h100123, 0, 8'h00, 1,0,0, 23'h100123, 8'h00, 8'hFF, 0));
    vecs.push_back(mk("rd2", 1,0,0,1, 8'h00, 23'h100123, 0, 8'h00, 1,0,0, 23'h100123, 8'h00, 8'hFF, 0));
    vecs.push_back(mk("rd3", 1,0,0,1, 8'h00, 23'h100123, 1, 8'h5A, 0,1,0, 23'h100123, 8'h00, 8'h5A, 1));
    vecs.push_back(mk("rd4", 1,0,0,1, 8'h00, 23'h100123, 1, 8'h00, 0,1,0, 23'h100123, 8'h00, 8'h5A, 1));
    vecs.push_back(mk("rd5", 0,0,1,1, 8'h00, 23'h100123, 0, 8'h00, 0,1,0, 23'h100123, 8'h00, 8'hFF, 0));
    vecs.push_back(mk("wr0", 1,1,1,0, 8'hC3, 23'h0004AB, 0, 8'h00, 1,0,1, 23'h0004AB, 8'hC3, 8'hFF, 0));
    vecs.push_back(mk("wr1", 1,1,1,0, 8'hC3, 23'h0004AB, 1, 8'h00, 0,1,1, 23'h0004AB, 8'hC3, 8'hFF, 0));
    vecs.push_back(mk("wr2", 1,1,1,1, 8'hC3, 23'h0004AB, 0, 8'h00, 0,1,1, 23'h0004AB, 8'hC3, 8'hFF, 0));
    vecs.push_back(mk("wr3", 1,1,1,0, 8'hC3, 23'h0004AB, 0, 8'h00, 0,1,1, 23'h0004AB, 8'hC3, 8'hFF, 0));
    vecs.push_back(mk("wr4", 0,1,1,1, 8'hC3, 23'h0004AB, 0, 8'h00, 0,1,1, 23'h0004AB, 8'hC3, 8'hFF, 0));
    vecs.push_back(mk("rom0", 1,0,1,0, 8'h11, 23'h7FFFFF, 0, 8'h00, 0,1,1, 23'h0004AB, 8'hC3, 8'hFF, 0));
    vecs.push_back(mk("rom1", 1,1,1,0, 8'h11, 23'h7FFFFF, 0, 8'h00, 0,1,1, 23'h0004AB, 8'hC3, 8'hFF, 0));
    vecs.push_back(mk("rom2", 0,0,1,1, 8'h11, 23'h7FFFFF, 0, 8'h00, 0,1,1, 23'h0004AB, 8'hC3, 8'hFF, 0));
    vecs.push_back(mk("pri0", 1,1,0,0, 8'h44, 23'h000777, 0, 8'h00, 1,0,0, 23'h000777, 8'h44, 8'hFF, 0));
    vecs.push_back(mk("pri1", 1,1,0,0, 8'h44, 23'h000777, 1, 8'h3C, 0,1,0, 23'h000777, 8'h44, 8'h3C, 1));
    vecs.push_back(mk("pri2", 0,1,1,1, 8'h44, 23'h000777, 0, 8'h00, 0,1,0, 23'h000777, 8'h44, 8'hFF, 0));
    vecs.push_back(mk("drop0", 1,0,0,1, 8'h00, 23'h2AAAAA, 0, 8'h00, 1,0,0, 23'h2AAAAA, 8'h00, 8'hFF, 0));
    vecs.push_back(mk("drop1", 0,0,1,1, 8'h00, 23'h2AAAAA, 0, 8'h00, 1,0,0, 23'h2AAAAA, 8'h00, 8'hFF, 0));
    vecs.push_back(mk("drop2", 0,0,1,1, 8'h00, 23'h2AAAAA, 0, 8'h00, 1,0,0, 23'h2AAAAA, 8'h00, 8'hFF, 0));
    vecs.push_back(mk("drop3", 0,0,1,1, 8'h00, 23'h2AAAAA, 0, 8'h00, 1,0,0, 23'h2AAAAA, 8'h00, 8'hFF, 0));
    vecs.push_back(mk("drop4", 0,0,1,1, 8'h00, 23'h2AAAAA, 0, 8'h00, 1,0,0, 23'h2AAAAA, 8'h00, 8'hFF, 0));
    vecs.push_back(mk("drop5", 0,0,1,1, 8'h00, 23'h2AAAAA, 1, 8'h99, 0,1,0, 23'h2AAAAA, 8'h00, 8'hFF, 0));
    vecs.push_back(mk("drop6", 0,0,1,1, 8'h00, 23'h2AAAAA, 1, 8'h99, 0,1,0, 23'h2AAAAA, 8'h00, 8'hFF, 0));
    vecs.push_back(mk("min0", 1,0,0,1, 8'h00, 23'h000001, 0, 8'h00, 1,0,0, 23'h000001, 8'h00, 8'hFF, 0));
    vecs.push_back(mk("min1", 1,0,0,1, 8'h00, 23'h000001, 1, 8'h01, 0,1,0, 23'h000001, 8'h00, 8'h01, 1));
    vecs.push_back(mk("min2", 0,0,1,1, 8'h00, 23'h000001, 0, 8'h00, 0,1,0, 23'h000001, 8'h00, 8'hFF, 0));

    #12;
    checkOutput("rst/mem_req",     32'(mem_req),     32'h0);
    checkOutput("rst/wait_n",      32'(wait_n),      32'h1);
    checkOutput("rst/cdout",       32'(cdout),       32'hFF);
    checkOutput("rst/cdout_valid", 32'(cdout_valid), 32'h0);
    checkOutput("rst/mem_wr",      32'(mem_wr),      32'h0);
    checkOutput("rst/mem_addr_o",  32'(mem_addr_o),  32'h0);
    checkOutput("rst/mem_wdata",   32'(mem_wdata),   32'h0);
    checkOutput("rst/timeout_err", 32'(timeout_err), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    req_rises = 0;

    foreach (vecs[i]) applyStimulus(vecs[i]);
    checkOutput("table/req_rises", 32'(req_rises), 32'd5);

    // reset while a read is outstanding, then a stray ack, then a normal read
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 23'h0355AA, 1'b0, 8'h00);
    @(posedge clk); #1;
    checkOutput("mrst/req_before", 32'(mem_req), 32'h1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("mrst/req_async",  32'(mem_req),    32'h0);
    checkOutput("mrst/wait_async", 32'(wait_n),     32'h1);
    checkOutput("mrst/addr_async", 32'(mem_addr_o), 32'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 23'h0, 1'b0, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 8'hEE;
    @(posedge clk); #1;
    checkOutput("mrst/late_ack_req",   32'(mem_req),     32'h0);
    checkOutput("mrst/late_ack_valid", 32'(cdout_valid), 32'h0);
    checkOutput("mrst/late_ack_cdout", 32'(cdout),       32'hFF);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 23'h000ABC, 1'b0, 8'h00);
    @(posedge clk); #1;
    checkOutput("mrst/next_req",  32'(mem_req),    32'h1);
    checkOutput("mrst/next_addr", 32'(mem_addr_o), 32'h000ABC);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    @(posedge clk); #1;
    checkOutput("mrst/next_cdout", 32'(cdout),       32'hA5);
    checkOutput("mrst/next_valid", 32'(cdout_valid), 32'h1);
    checkOutput("mrst/next_wait",  32'(wait_n),      32'h1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 23'h0, 1'b0, 8'h00);
    @(posedge clk); #1;
    checkOutput("mrst/end_cdout", 32'(cdout), 32'hFF);

`ifdef MEM_BRIDGE_TIMEOUT_EN
    // no ack: request stays up for 16 cycles, then aborts with FF and a sticky error
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 23'h000100, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("tmo/req_%0d", i), 32'(mem_req), 32'h1);
    end
    @(posedge clk); #1;
    checkOutput("tmo/req_abort", 32'(mem_req),     32'h0);
    checkOutput("tmo/wait",      32'(wait_n),      32'h1);
    checkOutput("tmo/cdout",     32'(cdout),       32'hFF);
    checkOutput("tmo/valid",     32'(cdout_valid), 32'h1);
    checkOutput("tmo/err",       32'(timeout_err), 32'h1);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 8'h12;
    @(posedge clk); #1;
    checkOutput("tmo/late_ack_cdout", 32'(cdout), 32'hFF);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 23'h0, 1'b0, 8'h00);
    @(posedge clk); #1;
    checkOutput("tmo/end_valid", 32'(cdout_valid), 32'h0);
    checkOutput("tmo/err_sticky", 32'(timeout_err), 32'h1);
`else
    checkOutput("notmo/err", 32'(timeout_err), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
